fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Fetch-stage controller for the 5-stage pipeline. Owns the program counter, drives the combinational instruction memory address, and registers the fetched word into the IF/ID pipeline register. Resolves next-PC among sequential increment, hazard stall and EX-stage branch redirect. Detects the EXIT word, drains the pipeline and raises `halted`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `EXIT_INSN`, 32'hFFFF_FFFF: instruction word that terminates execution.
- `NOP_INSN`, 32'h0000_0013: bubble written into IF/ID on flush or stall-free idle (`addi x0,x0,0`).
- `DRAIN_CYCLES`, 4: cycles spent in DRAIN before `halted` asserts (range 1..15).

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `pc_write`  in  1  from hazard unit; 0 = hold PC and IF/ID (load-use stall).
- `branch_taken`  in  1  from EX stage; redirect request, valid for one cycle.
- `branch_target`  in  32  redirect address; sampled only when `branch_taken`=1.
- `instruction`  in  32  instruction memory read data for the current `pc` (combinational).
- `pc`  out  32  current fetch address to instruction memory.
- `if_id_pc`  out  32  PC of the instruction held in IF/ID.
- `if_id_instr`  out  32  instruction held in IF/ID.
- `if_id_valid`  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- `halted`  out  1  sticky; 1 once the pipeline has drained after EXIT.
- `fetch_count`  out  32  instructions delivered to IF/ID (see Configuration).
- `stall_count`  out  32  stall cycles observed (see Configuration).

## Operation
- States: RUN, DRAIN, HALT. Reset → RUN.
- Reset values: `pc`=`RESET_PC`, `if_id_pc`=0, `if_id_instr`=`NOP_INSN`, `if_id_valid`=0, `halted`=0, counters 0, drain counter 0.
- RUN, priority highest first:
  - `branch_taken`=1: `pc`←`branch_target`; IF/ID ← bubble (`NOP_INSN`, valid 0). Overrides `pc_write`=0.
  - `pc_write`=0: `pc`, IF/ID and state hold.
  - `instruction`==`EXIT_INSN`: `pc` holds; IF/ID ← bubble (EXIT never enters IF/ID); drain counter ← `DRAIN_CYCLES`-1; → DRAIN.
  - otherwise: IF/ID ← {`pc`, `instruction`, valid 1}; `pc`←`pc`+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- DRAIN: `pc` frozen; IF/ID ← bubble each cycle regardless of `pc_write`.
  - `branch_taken`=1: EXIT was wrong-path; `pc`←`branch_target`, drain counter←0, → RUN.
  - else counter==0: → HALT; else counter decrements.
- HALT: `halted`=1; `pc` and IF/ID (bubble) frozen; all inputs ignored until `reset`.
- `branch_target` is used unaltered; bits [1:0] are not masked.

## Timing
- Fetch latency: word at `pc` is visible on `if_id_instr` one edge after it is presented, provided `pc_write`=1.
- Branch redirect: `pc`=target one edge after `branch_taken` is sampled; first target instruction reaches IF/ID on the following edge.
- Halt: EXIT sampled at edge t → DRAIN from t; `halted` rises after edge t+`DRAIN_CYCLES`.
- `reset` asserted mid-operation (any state) forces reset values asynchronously, without waiting for `clk`; first fetch from `RESET_PC` occurs on the first edge after deassertion.
- Outputs are all registered except `pc`, which is itself a register output; there are no combinational input→output paths.

## Configuration
- `FETCH_PERF_CNT_EN` defined: `fetch_count` increments on every edge that loads IF/ID with valid=1; `stall_count` increments on every RUN-state edge with `pc_write`=0 and `branch_taken`=0. Both saturate at 32'hFFFF_FFFF. Both clear on reset.
- Not defined: counter logic is not compiled; `fetch_count` and `stall_count` are tied to 0. The port list is unchanged.

## Test plan
- Sequential fetch: memory holds add words at 0..8, reset then run 3 cycles → `pc` 0→4→8→12, `if_id_pc`=8, `if_id_valid`=1, `fetch_count`=3.
- Stall: assert `pc_write`=0 for 2 cycles at `pc`=8 → `pc` and IF/ID unchanged, `stall_count`+=2; release → `pc`=12 on the next edge.
- Branch over stall: `pc_write`=0 with `branch_taken`=1, target 0x24 → `pc`=0x24, `if_id_valid`=0, `if_id_instr`=0x0000_0013.
- Exit: EXIT word at 0x40, `DRAIN_CYCLES`=4 → `pc` holds at 0x40, 4 bubble cycles, `halted`=1 after 4 edges, still 1 after 10 more cycles.
- Wrong-path exit: in DRAIN, `branch_taken`=1 with target 0x0C → state RUN, `pc`=0x0C, `halted` stays 0.
- Async reset mid-DRAIN: pulse `reset` between clock edges → `pc`=`RESET_PC`, `halted`=0 and `if_id_valid`=0 immediately, before the next edge.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch-stage bus: hazard/branch inputs, imem port, IF/ID register outputs
interface fetch_sequencer_if;
  logic        pc_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  // fetch_sequencer side
  modport master (
    input  pc_write, branch_taken, branch_target, instruction,
    output pc, if_id_pc, if_id_instr, if_id_valid
  );

  // pipeline / memory side
  modport slave (
    output pc_write, branch_taken, branch_target, instruction,
    input  pc, if_id_pc, if_id_instr, if_id_valid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage PC/IF-ID controller with EXIT drain; optional FETCH_PERF_CNT_EN counters
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] EXIT_INSN    = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_INSN     = 32'h0000_0013,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  fetch_sequencer_if.master         bus,
  output logic                      halted,
  output logic [31:0]               fetch_count,
  output logic [31:0]               stall_count
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] id_pc_q, id_pc_n;
  logic [31:0] id_instr_q, id_instr_n;
  logic        id_valid_q, id_valid_n;
  logic        halted_q, halted_n;
  logic [3:0]  drain_q, drain_n;
  logic        fetch_evt;
  logic        stall_evt;

  // State and pipeline register; reset clears everything asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP_INSN;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      drain_q    <= 4'h0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      id_pc_q    <= id_pc_n;
      id_instr_q <= id_instr_n;
      id_valid_q <= id_valid_n;
      halted_q   <= halted_n;
      drain_q    <= drain_n;
    end
  end

  // Next-PC / IF-ID selection: branch beats stall beats EXIT beats sequential fetch
  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    id_pc_n    = id_pc_q;
    id_instr_n = id_instr_q;
    id_valid_n = id_valid_q;
    halted_n   = halted_q;
    drain_n    = drain_q;
    fetch_evt  = 1'b0;
    stall_evt  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.branch_taken) begin
          pc_n       = bus.branch_target;
          id_instr_n = NOP_INSN;
          id_valid_n = 1'b0;
        end else if (!bus.pc_write) begin
          stall_evt = 1'b1;
        end else if (bus.instruction == EXIT_INSN) begin
          // EXIT is held at pc and never enters IF/ID
          id_instr_n = NOP_INSN;
          id_valid_n = 1'b0;
          drain_n    = DRAIN_LOAD;
          state_n    = DRAIN;
        end else begin
          id_pc_n    = pc_q;
          id_instr_n = bus.instruction;
          id_valid_n = 1'b1;
          pc_n       = pc_q + 32'd4;
          fetch_evt  = 1'b1;
        end
      end
      DRAIN: begin
        id_instr_n = NOP_INSN;
        id_valid_n = 1'b0;
        if (bus.branch_taken) begin
          // an older branch resolved taken: the EXIT was on the wrong path
          pc_n    = bus.branch_target;
          drain_n = 4'h0;
          state_n = RUN;
        end else if (drain_q == 4'h0) begin
          halted_n = 1'b1;
          state_n  = HALT;
        end else begin
          drain_n = drain_q - 4'h1;
        end
      end
      HALT: begin
        halted_n   = 1'b1;
        id_instr_n = NOP_INSN;
        id_valid_n = 1'b0;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.if_id_pc    = id_pc_q;
  assign bus.if_id_instr = id_instr_q;
  assign bus.if_id_valid = id_valid_q;
  assign halted          = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Saturating performance counters for delivered instructions and stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (fetch_evt && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_evt && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  logic unused_evt;
  assign unused_evt  = fetch_evt ^ stall_evt;
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] EXIT = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  logic [31:0] mem [64];

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .halted      (halted),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] instr;
    logic        valid;
    logic        halt;
    logic [31:0] fc;
    logic [31:0] sc;
    logic        chk_id_pc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: distinct word per index, EXIT at 0x40
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0033 | (32'(i) << 7);
    mem[16] = EXIT;
  end
  assign bus.instruction = mem[bus.pc[7:2]];

  function automatic logic [31:0] w(input logic [31:0] a);
    return mem[a[7:2]];
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] epc, eid, einstr, input logic ev, eh,
                      input logic [31:0] efc, esc, input logic cid, input string nm);
    exp_t e;
    e.pc = epc; e.id_pc = eid; e.instr = einstr; e.valid = ev; e.halt = eh;
`ifdef FETCH_PERF_CNT_EN
    e.fc = efc; e.sc = esc;
`else
    e.fc = 32'h0; e.sc = 32'h0;
`endif
    e.chk_id_pc = cid; e.name = nm;
    q.push_back(e);
  endtask

  task automatic cyc(input logic pw, br, input logic [31:0] tgt,
                     input logic [31:0] epc, eid, einstr, input logic ev, eh,
                     input logic [31:0] efc, esc, input logic cid, input string nm);
    bus.pc_write = pw; bus.branch_taken = br; bus.branch_target = tgt;
    @(posedge clk);
    #1 push(epc, eid, einstr, ev, eh, efc, esc, cid, nm);
  endtask

  task automatic areset(input string nm);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 push(32'h0, 32'h0, NOP, 1'b0, 1'b0, 0, 0, 1'b1, nm);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: compare the registered outputs against the oldest expectation each negedge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "pc", bus.pc, e.pc);
        if (e.chk_id_pc) chk(e.name, "if_id_pc", bus.if_id_pc, e.id_pc);
        chk(e.name, "if_id_instr", bus.if_id_instr, e.instr);
        chk(e.name, "if_id_valid", 32'(bus.if_id_valid), 32'(e.valid));
        chk(e.name, "halted", 32'(halted), 32'(e.halt));
        chk(e.name, "fetch_count", fetch_count, e.fc);
        chk(e.name, "stall_count", stall_count, e.sc);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.pc_write = 1'b1; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    #3 push(32'h0, 32'h0, NOP, 1'b0, 1'b0, 0, 0, 1'b1, "reset");
    @(negedge clk);
    #1 reset = 1'b0;

    cyc(1, 0, 0, 32'h04, 32'h00, w(32'h00), 1, 0, 1, 0, 1, "seq0");
    cyc(1, 0, 0, 32'h08, 32'h04, w(32'h04), 1, 0, 2, 0, 1, "seq1");
    cyc(1, 0, 0, 32'h0C, 32'h08, w(32'h08), 1, 0, 3, 0, 1, "seq2");
    cyc(0, 0, 0, 32'h0C, 32'h08, w(32'h08), 1, 0, 3, 1, 1, "stall1");
    cyc(0, 0, 0, 32'h0C, 32'h08, w(32'h08), 1, 0, 3, 2, 1, "stall2");
    cyc(1, 0, 0, 32'h10, 32'h0C, w(32'h0C), 1, 0, 4, 2, 1, "release");
    cyc(0, 1, 32'h24, 32'h24, 0, NOP, 0, 0, 4, 2, 0, "br_over_stall");
    cyc(1, 0, 0, 32'h28, 32'h24, w(32'h24), 1, 0, 5, 2, 1, "br_target_fetch");
    cyc(1, 1, 32'h3C, 32'h3C, 0, NOP, 0, 0, 5, 2, 0, "br_3c");
    cyc(1, 0, 0, 32'h40, 32'h3C, w(32'h3C), 1, 0, 6, 2, 1, "fetch_3c");
    cyc(1, 0, 0, 32'h40, 0, NOP, 0, 0, 6, 2, 0, "exit");
    cyc(0, 0, 0, 32'h40, 0, NOP, 0, 0, 6, 2, 0, "drain1");
    cyc(1, 0, 0, 32'h40, 0, NOP, 0, 0, 6, 2, 0, "drain2");
    cyc(1, 0, 0, 32'h40, 0, NOP, 0, 0, 6, 2, 0, "drain3");
    cyc(1, 0, 0, 32'h40, 0, NOP, 0, 1, 6, 2, 0, "halt");
    for (int i = 0; i < 10; i++)
      cyc(logic'(i % 2), logic'(i == 3), 32'h80, 32'h40, 0, NOP, 0, 1, 6, 2, 0, "halt_hold");
    areset("reset_in_halt");

    cyc(1, 1, 32'h40, 32'h40, 0, NOP, 0, 0, 0, 0, 0, "br_to_exit");
    cyc(1, 0, 0, 32'h40, 0, NOP, 0, 0, 0, 0, 0, "exit2");
    cyc(1, 0, 0, 32'h40, 0, NOP, 0, 0, 0, 0, 0, "drain_a");
    cyc(1, 1, 32'h0C, 32'h0C, 0, NOP, 0, 0, 0, 0, 0, "wrong_path");
    cyc(1, 0, 0, 32'h10, 32'h0C, w(32'h0C), 1, 0, 1, 0, 1, "resume");
    cyc(0, 0, 0, 32'h10, 32'h0C, w(32'h0C), 1, 0, 1, 1, 1, "stall3");
    cyc(1, 1, 32'h40, 32'h40, 0, NOP, 0, 0, 1, 1, 0, "br_to_exit2");
    cyc(1, 0, 0, 32'h40, 0, NOP, 0, 0, 1, 1, 0, "exit3");
    cyc(0, 0, 0, 32'h40, 0, NOP, 0, 0, 1, 1, 0, "drain_no_stall_cnt");
    areset("reset_in_drain");

    cyc(1, 0, 0, 32'h04, 32'h00, w(32'h00), 1, 0, 1, 0, 1, "post_reset");
    cyc(1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, NOP, 0, 0, 1, 0, 0, "br_top");
    cyc(1, 0, 0, 32'h0, 32'hFFFF_FFFC, w(32'hFFFF_FFFC), 1, 0, 2, 0, 1, "wrap");
    cyc(1, 1, 32'h02, 32'h02, 0, NOP, 0, 0, 2, 0, 0, "br_unaligned");
    cyc(1, 0, 0, 32'h06, 32'h02, w(32'h02), 1, 0, 3, 0, 1, "unaligned_fetch");

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
